// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two data-memory requesters (CPU MEM stage, DMA port),
// the arbiter and the data memory. The slave view belongs to the arbiter; the
// master view is the surrounding system (pipeline, DMA engine, memory).
interface dmem_arbiter_if #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
);
  // CPU side
  logic                  cpu_rd;
  logic                  cpu_wr;
  logic [DM_ADDRESS-1:0] cpu_addr;
  logic [DATA_W-1:0]     cpu_wdata;
  logic [2:0]            cpu_func3;
  logic                  cpu_stall;
  logic [DATA_W-1:0]     cpu_rdata;
  logic                  cpu_rvalid;
  // DMA side
  logic                  dma_valid;
  logic                  dma_we;
  logic [DM_ADDRESS-1:0] dma_addr;
  logic [DATA_W-1:0]     dma_wdata;
  logic                  dma_ready;
  logic [DATA_W-1:0]     dma_rdata;
  logic                  dma_rvalid;
  // Data-memory side
  logic                  mem_rd;
  logic                  mem_wr;
  logic [DM_ADDRESS-1:0] mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [2:0]            mem_func3;
  logic [DATA_W-1:0]     mem_rdata;

  modport slave (
    input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata, cpu_func3,
    output cpu_stall, cpu_rdata, cpu_rvalid,
    input  dma_valid, dma_we, dma_addr, dma_wdata,
    output dma_ready, dma_rdata, dma_rvalid,
    output mem_rd, mem_wr, mem_addr, mem_wdata, mem_func3,
    input  mem_rdata
  );

  modport master (
    output cpu_rd, cpu_wr, cpu_addr, cpu_wdata, cpu_func3,
    input  cpu_stall, cpu_rdata, cpu_rvalid,
    output dma_valid, dma_we, dma_addr, dma_wdata,
    input  dma_ready, dma_rdata, dma_rvalid,
    input  mem_rd, mem_wr, mem_addr, mem_wdata, mem_func3,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: shares one memory port between the CPU MEM stage
// and a DMA/loader port. CPU has fixed priority unless DMA has waited
// STARVE_LIM cycles. Writes complete in the issue cycle; at most one read is
// outstanding, returning MEM_LAT cycles after issue.
module dmem_arbiter #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_LIM = 4
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);
  localparam int LAT_W = $clog2(MEM_LAT + 1);
  localparam int STV_W = $clog2(STARVE_LIM + 1);

  typedef enum logic { IDLE, BUSY } state_t;
  typedef enum logic { OWN_CPU, OWN_DMA } owner_t;

  state_t            state;
  owner_t            owner;
  logic [LAT_W-1:0]  lat_cnt;
  logic [STV_W-1:0]  starve_cnt;

  logic                  cpu_req;
  logic                  starved;
  logic                  can_issue;
  logic                  grant_cpu;
  logic                  grant_dma;
  logic                  rd_done;
  logic                  cpu_rvalid_i;
  logic                  dma_rvalid_i;
  logic [DM_ADDRESS-1:0] addr_sel;
  logic [DATA_W-1:0]     wdata_sel;

  assign cpu_req   = bus.cpu_rd | bus.cpu_wr;
  assign starved   = (starve_cnt == STV_W'(STARVE_LIM));
  // Holding reset keeps every output quiet even if requesters are active.
  assign can_issue = !reset && (state == IDLE);

  // Read return is decoded purely from registered state: the cycle in which
  // the latency counter reaches 1 is the one where mem_rdata is valid.
  assign rd_done      = (state == BUSY) && (lat_cnt == LAT_W'(1));
  assign cpu_rvalid_i = rd_done && (owner == OWN_CPU);
  assign dma_rvalid_i = rd_done && (owner == OWN_DMA);

  // Issue decision: starved DMA first, then CPU, then DMA.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    grant_cpu = 1'b0;
    grant_dma = 1'b0;
    if (can_issue) begin
      if (bus.dma_valid && starved) grant_dma = 1'b1;
      else if (cpu_req)             grant_cpu = 1'b1;
      else if (bus.dma_valid)       grant_dma = 1'b1;
    end
  end

  // Drive the memory port from the granted requester; idle port is all zero.
  // Only request-side inputs feed this mux, never mem_rdata.
  always_comb begin
    bus.mem_rd    = 1'b0;
    bus.mem_wr    = 1'b0;
    bus.mem_func3 = 3'b000;
    addr_sel      = '0;
    wdata_sel     = '0;
    if (grant_cpu) begin
      bus.mem_wr    = bus.cpu_wr;
      bus.mem_rd    = !bus.cpu_wr;          // write wins when both are set
      bus.mem_func3 = bus.cpu_func3;
      addr_sel      = bus.cpu_addr;
      wdata_sel     = bus.cpu_wdata;
    end else if (grant_dma) begin
      bus.mem_wr    = bus.dma_we;
      bus.mem_rd    = !bus.dma_we;
      bus.mem_func3 = 3'b010;               // DMA always moves full words
      addr_sel      = bus.dma_addr;
      wdata_sel     = bus.dma_wdata;
    end
  end

  assign bus.mem_addr   = addr_sel;
  assign bus.mem_wdata  = wdata_sel;
  assign bus.dma_ready  = grant_dma;
  assign bus.cpu_rvalid = cpu_rvalid_i;
  assign bus.dma_rvalid = dma_rvalid_i;
  assign bus.cpu_rdata  = cpu_rvalid_i ? bus.mem_rdata : '0;
  assign bus.dma_rdata  = dma_rvalid_i ? bus.mem_rdata : '0;
  // Freeze the pipeline until a CPU write is issued or its read data returns.
  assign bus.cpu_stall  = !reset && cpu_req && !(grant_cpu && bus.cpu_wr) && !cpu_rvalid_i;

  // Read-tracking FSM: IDLE issues, BUSY counts the read latency down.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: the async reset clears the FSM so a read in flight is simply dropped; no rvalid follows.
    if (reset) begin
      state   <= IDLE;
      owner   <= OWN_CPU;
      lat_cnt <= '0;
    end else begin
      // NOTE: registered state is updated with non-blocking assignments only.
      case (state)
        IDLE: begin
          if ((grant_cpu && !bus.cpu_wr) || (grant_dma && !bus.dma_we)) begin
            state   <= BUSY;
            owner   <= grant_dma ? OWN_DMA : OWN_CPU;
            lat_cnt <= LAT_W'(MEM_LAT);
          end
        end
        BUSY: begin
          lat_cnt <= lat_cnt - LAT_W'(1);
          if (lat_cnt == LAT_W'(1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Starvation counter: counts DMA wait cycles, saturating at STARVE_LIM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!bus.dma_valid || grant_dma) begin
      starve_cnt <= '0;
    end else if (!starved) begin
      starve_cnt <= starve_cnt + STV_W'(1);
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: one instance with MEM_LAT=1, one with
// MEM_LAT=3, both with STARVE_LIM=4. Inputs change 1 time unit after the
// rising edge; outputs are sampled on the falling edge.
module tb_dmem_arbiter;
  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  dmem_arbiter_if #(.DM_ADDRESS(9), .DATA_W(32)) a ();
  dmem_arbiter_if #(.DM_ADDRESS(9), .DATA_W(32)) b ();

  dmem_arbiter #(.DM_ADDRESS(9), .DATA_W(32), .MEM_LAT(1), .STARVE_LIM(4)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (a)
  );

  dmem_arbiter #(.DM_ADDRESS(9), .DATA_W(32), .MEM_LAT(3), .STARVE_LIM(4)) dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset = 1'b1;
    a.cpu_rd = 0; a.cpu_wr = 0; a.cpu_addr = '0; a.cpu_wdata = '0; a.cpu_func3 = '0;
    a.dma_valid = 0; a.dma_we = 0; a.dma_addr = '0; a.dma_wdata = '0; a.mem_rdata = '0;
    b.cpu_rd = 0; b.cpu_wr = 0; b.cpu_addr = '0; b.cpu_wdata = '0; b.cpu_func3 = '0;
    b.dma_valid = 0; b.dma_we = 0; b.dma_addr = '0; b.dma_wdata = '0; b.mem_rdata = '0;

    // Reset state: all outputs zero
    sample();
    check("rst_cpu_stall",  32'(a.cpu_stall),  32'd0);
    check("rst_dma_ready",  32'(a.dma_ready),  32'd0);
    check("rst_rvalids",    32'({a.cpu_rvalid, a.dma_rvalid}), 32'd0);
    check("rst_mem_rdwr",   32'({a.mem_rd, a.mem_wr}), 32'd0);
    check("rst_mem_addr",   32'(a.mem_addr),   32'd0);
    check("rst_mem_wdata",  a.mem_wdata,       32'd0);
    check("rst_mem_func3",  32'(a.mem_func3),  32'd0);
    step();
    reset = 1'b0;

    // CPU read, MEM_LAT=1: stall in issue cycle, data the next
    step();
    a.cpu_rd = 1; a.cpu_addr = 9'h010; a.cpu_func3 = 3'b010; a.mem_rdata = 32'hDEADBEEF;
    sample();
    check("rd_mem_rd",      32'(a.mem_rd),     32'd1);
    check("rd_mem_addr",    32'(a.mem_addr),   32'h010);
    check("rd_stall_issue", 32'(a.cpu_stall),  32'd1);
    check("rd_rvalid_early",32'(a.cpu_rvalid), 32'd0);
    step();
    sample();
    check("rd_rvalid",      32'(a.cpu_rvalid), 32'd1);
    check("rd_rdata",       a.cpu_rdata,       32'hDEADBEEF);
    check("rd_stall_done",  32'(a.cpu_stall),  32'd0);
    check("rd_no_reissue",  32'(a.mem_rd),     32'd0);

    // CPU write completes in the issue cycle
    step();
    a.cpu_rd = 0; a.cpu_wr = 1; a.cpu_addr = 9'h020; a.cpu_wdata = 32'h12345678; a.cpu_func3 = 3'b010;
    sample();
    check("wr_mem_wr",      32'({a.mem_rd, a.mem_wr}), 32'd1);
    check("wr_mem_addr",    32'(a.mem_addr),   32'h020);
    check("wr_mem_wdata",   a.mem_wdata,       32'h12345678);
    check("wr_mem_func3",   32'(a.mem_func3),  32'b010);
    check("wr_no_stall",    32'(a.cpu_stall),  32'd0);
    // FSM stayed IDLE: a DMA write issues right away
    step();
    a.cpu_wr = 0; a.dma_valid = 1; a.dma_we = 1; a.dma_addr = 9'h030; a.dma_wdata = 32'hA5A5A5A5;
    sample();
    check("wr_idle_dma_rdy",32'(a.dma_ready),  32'd1);
    check("dmawr_mem_wr",   32'({a.mem_rd, a.mem_wr}), 32'd1);
    check("dmawr_addr",     32'(a.mem_addr),   32'h030);
    check("dmawr_func3",    32'(a.mem_func3),  32'b010);

    // Simultaneous CPU read and DMA read: CPU first
    step();
    a.dma_valid = 1; a.dma_we = 0; a.dma_addr = 9'h044;
    a.cpu_rd = 1; a.cpu_addr = 9'h040; a.mem_rdata = 32'hCAFEF00D;
    sample();
    check("both_cpu_addr",  32'(a.mem_addr),   32'h040);
    check("both_dma_wait",  32'(a.dma_ready),  32'd0);
    check("both_cpu_stall", 32'(a.cpu_stall),  32'd1);
    step();
    sample();
    check("both_cpu_rvalid",32'(a.cpu_rvalid), 32'd1);
    check("both_cpu_rdata", a.cpu_rdata,       32'hCAFEF00D);
    check("both_busy_nordy",32'(a.dma_ready),  32'd0);
    step();
    a.cpu_rd = 0;
    sample();
    check("both_dma_ready", 32'(a.dma_ready),  32'd1);
    check("both_dma_addr",  32'(a.mem_addr),   32'h044);
    check("both_dma_rd",    32'(a.mem_rd),     32'd1);
    step();
    a.dma_valid = 0; a.mem_rdata = 32'h11223344;
    sample();
    check("both_dma_rvalid",32'(a.dma_rvalid), 32'd1);
    check("both_dma_rdata", a.dma_rdata,       32'h11223344);
    check("both_cpu_quiet", 32'(a.cpu_rvalid), 32'd0);

    // Starvation: CPU writes every cycle, DMA write held; DMA wins on cycle 5
    for (int i = 0; i < 4; i++) begin
      step();
      a.cpu_wr = 1; a.cpu_addr = 9'(9'h050 + i); a.cpu_wdata = 32'h100 + i;
      a.dma_valid = 1; a.dma_we = 1; a.dma_addr = 9'h060; a.dma_wdata = 32'h0BADF00D;
      sample();
      check("stv_cpu_addr",   32'(a.mem_addr),  32'h050 + i);
      check("stv_dma_wait",   32'(a.dma_ready), 32'd0);
      check("stv_cpu_nostall",32'(a.cpu_stall), 32'd0);
    end
    step();
    a.cpu_addr = 9'h054; a.cpu_wdata = 32'h104;
    sample();
    check("stv5_dma_ready", 32'(a.dma_ready),  32'd1);
    check("stv5_addr",      32'(a.mem_addr),   32'h060);
    check("stv5_wdata",     a.mem_wdata,       32'h0BADF00D);
    check("stv5_cpu_stall", 32'(a.cpu_stall),  32'd1);
    step();
    a.dma_valid = 0;
    sample();
    check("stv6_cpu_wr",    32'({a.mem_wr, a.mem_addr}), {22'd0, 1'b1, 9'h054});
    check("stv6_no_stall",  32'(a.cpu_stall),  32'd0);

    // DMA read dropped by a reset pulse while BUSY
    step();
    a.cpu_wr = 0; a.dma_valid = 1; a.dma_we = 0; a.dma_addr = 9'h004; a.mem_rdata = 32'h99887766;
    sample();
    check("rstmid_issue",   32'({a.dma_ready, a.mem_rd, a.mem_addr}), {21'd0, 2'b11, 9'h004});
    step();
    a.dma_valid = 0; reset = 1'b1;
    sample();
    check("rstmid_no_rvalid", 32'(a.dma_rvalid), 32'd0);
    check("rstmid_outputs",   32'({a.cpu_stall, a.dma_ready, a.cpu_rvalid, a.mem_rd, a.mem_wr}), 32'd0);
    check("rstmid_rdata",     a.dma_rdata, 32'd0);
    step();
    reset = 1'b0;
    sample();
    check("rstmid_after",   32'({a.dma_rvalid, a.mem_rd, a.mem_wr}), 32'd0);
    step();
    a.cpu_rd = 1; a.cpu_addr = 9'h010; a.mem_rdata = 32'h55AA55AA;
    sample();
    check("rstcpu_issue",   32'({a.mem_rd, a.cpu_stall}), 32'b11);
    step();
    sample();
    check("rstcpu_rvalid",  32'({a.cpu_rvalid, a.cpu_stall}), 32'b10);
    check("rstcpu_rdata",   a.cpu_rdata, 32'h55AA55AA);
    step();
    a.cpu_rd = 0;

    // MEM_LAT=3: DMA read returns 3 cycles after dma_ready, port blocked meanwhile
    b.dma_valid = 1; b.dma_we = 0; b.dma_addr = 9'h008;
    sample();
    check("l3_dma_ready",   32'({b.dma_ready, b.mem_rd, b.mem_addr}), {21'd0, 2'b11, 9'h008});
    step();
    b.dma_valid = 0; b.cpu_rd = 1; b.cpu_addr = 9'h00C; b.mem_rdata = 32'h0F0F0F0F;
    for (int k = 1; k <= 3; k++) begin
      if (k > 1) step();
      sample();
      check("l3_no_issue",  32'({b.mem_rd, b.mem_wr}), 32'd0);
      check("l3_dma_rvalid",32'(b.dma_rvalid), (k == 3) ? 32'd1 : 32'd0);
      check("l3_cpu_stall", 32'(b.cpu_stall), 32'd1);
    end
    check("l3_dma_rdata",   b.dma_rdata, 32'h0F0F0F0F);
    step();
    b.mem_rdata = 32'h76543210;
    sample();
    check("l3_cpu_issue",   32'({b.mem_rd, b.mem_addr}), {22'd0, 1'b1, 9'h00C});
    check("l3_dma_quiet",   32'(b.dma_rvalid), 32'd0);
    for (int k = 1; k <= 3; k++) begin
      step();
      sample();
      check("l3_cpu_rvalid", 32'(b.cpu_rvalid), (k == 3) ? 32'd1 : 32'd0);
      check("l3_cpu_stall2", 32'(b.cpu_stall),  (k == 3) ? 32'd0 : 32'd1);
    end
    check("l3_cpu_rdata",   b.cpu_rdata, 32'h76543210);
    step();
    b.cpu_rd = 0;
    sample();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
